display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter DIV, default 50000: clock cycles each digit is driven (DRIVE dwell); legal range 2..65535.
REQ-002 Parameter BLANK, default 16: all-anodes-off cycles before each digit (anti-ghosting); legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 holds the block in IDLE with the display dark.
REQ-006 data_in  input  32  eight hex nibbles; digit k is data_in[4k+3:4k].
REQ-007 dp_in  input  8  decimal-point request per digit, 1 = lit.
REQ-008 digit_en  input  8  per-digit enable, 0 = digit blanked.
REQ-009 sel  output  3  current digit index, driving the select of the downstream anode/data mux.
REQ-010 anode  output  8  active-low anode drive; at most one bit low at any time.
REQ-011 hex_out  output  4  nibble for the current digit, feeding the seven-segment decoder.
REQ-012 dp_out  output  1  active-low decimal point for the current digit.
REQ-013 frame_tick  output  1  one-cycle pulse at the end of each complete 8-digit frame.

Function
REQ-014 The FSM SHALL have states IDLE, BLANK and DRIVE.
REQ-015 In IDLE: anode=8'hFF, sel=0, dwell counter cleared; when en=1, the FSM SHALL go to BLANK on the next edge and snapshot data_in, dp_in and digit_en into shadow registers.
REQ-016 BLANK SHALL hold anode=8'hFF for exactly BLANK cycles, then go to DRIVE.
REQ-017 DRIVE SHALL last exactly DIV cycles, with anode[sel]=0 only if shadow digit_en[sel]=1 and all other anode bits 1.
REQ-018 When DRIVE ends, sel SHALL increment modulo 8 (7 wraps to 0) and the FSM SHALL return to BLANK; a blanked digit keeps its full time slot (constant duty, no skipping).
REQ-019 On the 7->0 wrap, frame_tick SHALL be 1 for exactly one cycle, coincident with the first BLANK cycle of the new frame, and the shadow registers SHALL reload from the inputs on that same edge.
REQ-020 Input changes between frame boundaries SHALL NOT affect outputs (no tearing within a frame).
REQ-021 hex_out SHALL equal shadow data[4*sel+3:4*sel] and dp_out SHALL equal ~shadow dp[sel]; both are valid in BLANK and DRIVE and are 4'h0 and 1 in IDLE.
REQ-022 All outputs SHALL be registered; the per-digit period is BLANK+DIV cycles and the frame period is 8*(BLANK+DIV) cycles.
REQ-023 en falling in any state SHALL force IDLE on the next edge, with anode=8'hFF and no frame_tick; the next en rise SHALL restart at sel=0.
REQ-024 The dwell counter SHALL be 16 bits wide and reset to 0 at each state entry; no overflow is possible within the legal parameter range.

Reset
REQ-025 While reset=1 (asynchronous): state=IDLE, sel=0, anode=8'hFF, hex_out=4'h0, dp_out=1, frame_tick=0, shadow registers and counter 0.
REQ-026 Reset asserted mid-frame SHALL darken the display immediately, without waiting for a clock edge.
REQ-027 After reset deasserts with en=1, the first BLANK state SHALL begin on the second rising edge.

Structure
REQ-028 The FSM state encoding and the DIV and BLANK defaults SHALL live in a shared package, for reuse by the seven-segment top level.
REQ-029 The nibble and decimal-point selection SHALL be a separate sub-module, digit_sel_mux (combinational: sel to nibble and dp); the sequencing logic SHALL stay in display_scan_ctrl.

Verification (DIV=4, BLANK=2 unless stated)
REQ-030 Reset, then en=1, data_in=32'h76543210, digit_en=8'hFF -> anode sequence FE,FD,...,7F; each value held 4 cycles with 2 cycles of FF between; hex_out equals sel throughout.
REQ-031 Free run with en=1 -> frame_tick is high exactly once every 48 cycles, on the sel 7->0 transition.
REQ-032 Change data_in to 32'hFFFFFFFF while sel=3 -> hex_out stays at the old nibbles until the wrap, then reads F.
REQ-033 digit_en=8'b1010_1010, dp_in=8'h01 -> anode stays FF during the slots for digits 0, 2, 4 and 6; dp_out=0 only while sel=0.
REQ-034 Drop en at sel=5 mid-DRIVE -> anode=FF on the next cycle with no frame_tick; raise en again -> the scan restarts at sel=0.
REQ-035 Assert reset asynchronously between clock edges mid-DRIVE -> anode=FF before the next edge; a checker confirms at most one anode bit low in every cycle.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the eight-digit multiplexed display scanner.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Holds the scan FSM state encoding and the default timing parameters so the
// seven-segment top level can reuse them without duplicating constants.
package display_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // Default DRIVE dwell (cycles per digit) and anti-ghosting BLANK gap.
   localparam int DIV_DEFAULT   = 50000;
   localparam int BLANK_DEFAULT = 16;

   // Active-low anodes: all ones means the display is dark.
   localparam logic [7:0] ANODE_OFF = 8'hFF;

   // Nibble idx of a packed eight-digit hex word.
   function automatic logic [3:0] nibble_at(input logic [31:0] data,
                                            input logic [2:0]  idx);
      return data[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/display_scan_ctrl_digit_sel_mux.sv
// Selects the nibble and decimal-point bit of the current digit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   sel    - digit index 0..7
//   data   - eight packed hex nibbles, digit k at data[4k+3:4k]
//   dp     - per-digit decimal point request, 1 = lit
//   nibble - selected nibble
//   dp_bit - selected decimal-point request (active high)
module digit_sel_mux
   import display_scan_ctrl_pkg::*;
(
   input  logic [2:0]  sel,
   input  logic [31:0] data,
   input  logic [7:0]  dp,
   output logic [3:0]  nibble,
   output logic        dp_bit
);

   assign nibble = nibble_at(data, sel);
   assign dp_bit = dp[sel];

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed display scanner: BLANK gap then DRIVE dwell per digit.
// Latency: all outputs registered; digit period BLANK+DIV, frame 8*(BLANK+DIV).
// Backpressure: none; en=0 drops to IDLE (dark) on the next edge.
//
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   en          - scan enable
//   data_in     - eight hex nibbles, dp_in decimal points, digit_en per-digit enable
//   sel         - current digit index
//   anode       - active-low anode drive, at most one bit low
//   hex_out     - current nibble; dp_out active-low decimal point
//   frame_tick  - one-cycle pulse on the first BLANK cycle after the 7->0 wrap
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int DIV   = DIV_DEFAULT,
   parameter int BLANK = BLANK_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  digit_en,
   output logic [2:0]  sel,
   output logic [7:0]  anode,
   output logic [3:0]  hex_out,
   output logic        dp_out,
   output logic        frame_tick
);

   localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
   localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

   scan_state_t state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  sel_d;
   logic [31:0] shd_data_q, shd_data_d;
   logic [7:0]  shd_dp_q, shd_dp_d;
   logic [7:0]  shd_en_q, shd_en_d;
   logic        armed_q;
   logic [7:0]  anode_d;
   logic [3:0]  hex_d;
   logic        dp_d;
   logic        tick_d;
   logic [3:0]  nib_nxt;
   logic        dp_nxt;

   // The mux looks at next-cycle sel/shadow values so hex_out and dp_out can be
   // registered yet still line up with sel and anode in the same cycle.
   digit_sel_mux u_mux (
      .sel    (sel_d),
      .data   (shd_data_d),
      .dp     (shd_dp_d),
      .nibble (nib_nxt),
      .dp_bit (dp_nxt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 16'd0;
         sel        <= 3'd0;
         shd_data_q <= 32'd0;
         shd_dp_q   <= 8'd0;
         shd_en_q   <= 8'd0;
         armed_q    <= 1'b0;
         anode      <= ANODE_OFF;
         hex_out    <= 4'h0;
         dp_out     <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel        <= sel_d;
         shd_data_q <= shd_data_d;
         shd_dp_q   <= shd_dp_d;
         shd_en_q   <= shd_en_d;
         // One settle edge after reset release; the scan starts on the second.
         armed_q    <= 1'b1;
         anode      <= anode_d;
         hex_out    <= hex_d;
         dp_out     <= dp_d;
         frame_tick <= tick_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      sel_d      = sel;
      shd_data_d = shd_data_q;
      shd_dp_d   = shd_dp_q;
      shd_en_d   = shd_en_q;
      tick_d     = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = 16'd0;
         sel_d   = 3'd0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d = 16'd0;
               sel_d = 3'd0;
               if (armed_q) begin
                  state_d    = ST_BLANK;
                  shd_data_d = data_in;
                  shd_dp_d   = dp_in;
                  shd_en_d   = digit_en;
               end
            end
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_DRIVE;
                  cnt_d   = 16'd0;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == DIV_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = 16'd0;
                  sel_d   = sel + 3'd1;
                  // Frame boundary: tick and take a fresh snapshot together so
                  // a whole frame always shows one coherent set of inputs.
                  if (sel == 3'd7) begin
                     tick_d     = 1'b1;
                     shd_data_d = data_in;
                     shd_dp_d   = dp_in;
                     shd_en_d   = digit_en;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 16'd0;
               sel_d   = 3'd0;
            end
         endcase
      end

      // Blanked digits keep their slot but never pull an anode low.
      anode_d = ANODE_OFF;
      if (state_d == ST_DRIVE && shd_en_d[sel_d]) begin
         anode_d[sel_d] = 1'b0;
      end

      if (state_d == ST_IDLE) begin
         hex_d = 4'h0;
         dp_d  = 1'b1;
      end else begin
         hex_d = nib_nxt;
         dp_d  = ~dp_nxt;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic [2:0]  sel;
   logic [7:0]  anode;
   logic [3:0]  hex_out;
   logic        dp_out;
   logic        frame_tick;

   int n_checks = 0;
   int n_err    = 0;
   int frame_no = 0;

   display_scan_ctrl #(.DIV(4), .BLANK(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .sel        (sel),
      .anode      (anode),
      .hex_out    (hex_out),
      .dp_out     (dp_out),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  dp;
      logic [7:0]  den;
   } cfg_t;

   typedef struct {
      logic [7:0] anode;
      logic [3:0] hex;
      logic       dp_n;
   } slot_t;

   cfg_t  cfgs [3];
   slot_t tbl  [24];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply_cfg(input int k);
      data_in  = cfgs[k].data;
      dp_in    = cfgs[k].dp;
      digit_en = cfgs[k].den;
   endtask

   // Walks one 48-cycle frame (2 BLANK + 4 DRIVE per digit), sampling at negedge.
   task automatic run_frame(input int cfg, input bit first, input int chg_at,
                            input int chg_cfg, input int stop_at);
      slot_t e;
      int d, ph;
      logic [7:0] exp_an;
      frame_no++;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         d  = c / 6;
         ph = c % 6;
         e  = tbl[cfg*8 + d];
         exp_an = (ph < 2) ? 8'hFF : e.anode;
         chk($sformatf("sel f%0d c%0d", frame_no, c), 32'(sel), 32'(d));
         chk($sformatf("anode f%0d c%0d", frame_no, c), 32'(anode), 32'(exp_an));
         chk($sformatf("hex f%0d c%0d", frame_no, c), 32'(hex_out), 32'(e.hex));
         chk($sformatf("dp f%0d c%0d", frame_no, c), 32'(dp_out), 32'(e.dp_n));
         chk($sformatf("tick f%0d c%0d", frame_no, c), 32'(frame_tick),
             32'((c == 0 && !first) ? 1 : 0));
         chk($sformatf("onehot f%0d c%0d", frame_no, c),
             32'($countones(~anode) <= 1), 32'd1);
         if (c == chg_at) apply_cfg(chg_cfg);
         if (c == stop_at) begin
            en = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      cfgs[0] = '{32'h76543210, 8'h00, 8'hFF};
      cfgs[1] = '{32'hFFFFFFFF, 8'h00, 8'hFF};
      cfgs[2] = '{32'h89ABCDEF, 8'h01, 8'hAA};

      // cfg0: every digit lit, nibble equals index
      tbl[0]  = '{8'hFE, 4'h0, 1'b1};
      tbl[1]  = '{8'hFD, 4'h1, 1'b1};
      tbl[2]  = '{8'hFB, 4'h2, 1'b1};
      tbl[3]  = '{8'hF7, 4'h3, 1'b1};
      tbl[4]  = '{8'hEF, 4'h4, 1'b1};
      tbl[5]  = '{8'hDF, 4'h5, 1'b1};
      tbl[6]  = '{8'hBF, 4'h6, 1'b1};
      tbl[7]  = '{8'h7F, 4'h7, 1'b1};
      // cfg1: all F
      tbl[8]  = '{8'hFE, 4'hF, 1'b1};
      tbl[9]  = '{8'hFD, 4'hF, 1'b1};
      tbl[10] = '{8'hFB, 4'hF, 1'b1};
      tbl[11] = '{8'hF7, 4'hF, 1'b1};
      tbl[12] = '{8'hEF, 4'hF, 1'b1};
      tbl[13] = '{8'hDF, 4'hF, 1'b1};
      tbl[14] = '{8'hBF, 4'hF, 1'b1};
      tbl[15] = '{8'h7F, 4'hF, 1'b1};
      // cfg2: even digits blanked, dp on digit 0 only
      tbl[16] = '{8'hFF, 4'hF, 1'b0};
      tbl[17] = '{8'hFD, 4'hE, 1'b1};
      tbl[18] = '{8'hFF, 4'hD, 1'b1};
      tbl[19] = '{8'hF7, 4'hC, 1'b1};
      tbl[20] = '{8'hFF, 4'hB, 1'b1};
      tbl[21] = '{8'hDF, 4'hA, 1'b1};
      tbl[22] = '{8'hFF, 4'h9, 1'b1};
      tbl[23] = '{8'h7F, 4'h8, 1'b1};

      reset = 1'b1;
      en    = 1'b1;
      apply_cfg(0);
      #12;
      chk("rst anode", 32'(anode), 32'hFF);
      chk("rst sel", 32'(sel), 32'd0);
      chk("rst hex", 32'(hex_out), 32'h0);
      chk("rst dp", 32'(dp_out), 32'd1);
      chk("rst tick", 32'(frame_tick), 32'd0);

      @(negedge clk);
      reset = 1'b0;
      // First edge after release is a settle edge: still dark and idle.
      @(negedge clk);
      chk("settle anode", 32'(anode), 32'hFF);
      chk("settle sel", 32'(sel), 32'd0);
      chk("settle tick", 32'(frame_tick), 32'd0);

      // Frame 1: data changes mid-frame at sel=3, must not tear.
      run_frame(0, 1'b1, 20, 1, -1);
      // Frame 2: shows the all-F snapshot; switch to sparse config mid-frame.
      run_frame(1, 1'b0, 10, 2, -1);
      // Frame 3: sparse digits; drop en mid-DRIVE of digit 5.
      run_frame(2, 1'b0, -1, 0, 33);

      @(negedge clk);
      chk("en_off anode", 32'(anode), 32'hFF);
      chk("en_off tick", 32'(frame_tick), 32'd0);
      chk("en_off sel", 32'(sel), 32'd0);
      chk("en_off hex", 32'(hex_out), 32'h0);
      chk("en_off dp", 32'(dp_out), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("idle anode %0d", i), 32'(anode), 32'hFF);
      end
      en = 1'b1;
      // Restart begins at sel=0 with no tick on the first BLANK.
      run_frame(2, 1'b1, -1, 0, -1);

      // Advance into digit 1 DRIVE of the next frame, then reset between edges.
      for (int i = 0; i < 9; i++) @(negedge clk);
      chk("pre_rst anode", 32'(anode), 32'hFD);
      chk("pre_rst sel", 32'(sel), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async anode", 32'(anode), 32'hFF);
      chk("async sel", 32'(sel), 32'd0);
      chk("async hex", 32'(hex_out), 32'h0);
      chk("async dp", 32'(dp_out), 32'd1);
      chk("async tick", 32'(frame_tick), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
